md_unit: RTL and testbench

- Parametrised multiply/divide unit with architectural HI/LO registers for the E stage of the MIPS pipeline.
- Supersedes the combinational HI/LO read-out select. Adds these behaviours:
  - multi-cycle MULT/MULTU/DIV/DIVU with configurable latency
  - MTHI/MTLO writes
  - a busy handshake for the hazard unit
  - cancellation of a start in the same cycle by an exception or interrupt
- Read-out (MFHI/MFLO) feeds the E-stage result path.

---
 rtl/md_unit_if.sv | 42 ++++
 rtl/md_unit.sv | 186 ++++++++++++++++++
 tb/tb_md_unit.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/md_unit_if.sv
// md_unit E-stage bundle: start/op/operands
// in, busy and HI/LO read-out back.
interface md_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             cancel;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       rd_sel;
  logic             busy;
  logic [WIDTH-1:0] md_out;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start,
    output cancel,
    output op,
    output a,
    output b,
    output rd_sel,
    input  busy,
    input  md_out,
    input  hi,
    input  lo
  );

  modport slave (
    input  start,
    input  cancel,
    input  op,
    input  a,
    input  b,
    input  rd_sel,
    output busy,
    output md_out,
    output hi,
    output lo
  );
endinterface

// File: rtl/md_unit.sv
// MIPS E-stage multiply/divide unit with
// architectural HI/LO and busy handshake.
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic      clk,
  input  logic      reset,
  md_unit_if.slave  bus
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ?
    MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_t;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic w_accept;
  logic w_is_calc;
  logic w_done;

  logic [2*WIDTH-1:0] w_ma;
  logic [2*WIDTH-1:0] w_mb;
  logic [2*WIDTH-1:0] w_prod;

  logic             w_sgn;
  logic             w_neg_a;
  logic             w_neg_b;
  logic [WIDTH-1:0] w_ua;
  logic [WIDTH-1:0] w_ub;
  logic [WIDTH-1:0] w_uq;
  logic [WIDTH-1:0] w_ur;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_r;
  logic             w_is_mul;
  logic             w_div0;

  assign w_accept  = bus.start & ~bus.cancel &
                     (r_state == S_IDLE);
  assign w_is_calc = ~bus.op[2];
  assign w_done    = (r_state == S_BUSY) &&
                     (r_cnt == CW'(1));

  assign w_is_mul = (r_op == OP_MULT) ||
                    (r_op == OP_MULTU);

  // Sign/zero extend so one 2W-bit product
  // serves both MULT and MULTU.
  assign w_ma = (r_op == OP_MULT) ?
    {{WIDTH{r_a[WIDTH-1]}}, r_a} :
    {{WIDTH{1'b0}}, r_a};
  assign w_mb = (r_op == OP_MULT) ?
    {{WIDTH{r_b[WIDTH-1]}}, r_b} :
    {{WIDTH{1'b0}}, r_b};
  assign w_prod = w_ma * w_mb;

  // Signed divide via magnitudes; the most
  // negative / -1 case falls out naturally.
  assign w_sgn   = (r_op == OP_DIV);
  assign w_neg_a = w_sgn & r_a[WIDTH-1];
  assign w_neg_b = w_sgn & r_b[WIDTH-1];
  assign w_ua    = w_neg_a ? -r_a : r_a;
  assign w_ub    = w_neg_b ? -r_b : r_b;
  assign w_div0  = (r_b == '0);
  assign w_uq    = w_div0 ? '0 : w_ua / w_ub;
  assign w_ur    = w_div0 ? '0 : w_ua % w_ub;
  assign w_q     = (w_neg_a ^ w_neg_b) ?
                   -w_uq : w_uq;
  assign w_r     = w_neg_a ? -w_ur : w_ur;

  // State and latency counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: enter BUSY on an accepted
  // calc op, count down, leave at count 1.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_calc) begin
          w_state_nxt = S_BUSY;
          w_cnt_nxt = bus.op[1] ?
            CW'(DIV_CYCLES) :
            CW'(MULT_CYCLES);
        end
      end
      S_BUSY: begin
        w_cnt_nxt = r_cnt - CW'(1);
        if (w_done) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Operand capture, only on acceptance so
  // later changes on a/b are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op <= '0;
      r_a  <= '0;
      r_b  <= '0;
    end else if (w_accept && w_is_calc) begin
      r_op <= bus.op;
      r_a  <= bus.a;
      r_b  <= bus.b;
    end
  end

  // HI/LO: MTHI/MTLO on acceptance, results
  // on the last busy edge; /0 leaves both.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_done) begin
      if (w_is_mul) begin
        r_hi <= w_prod[2*WIDTH-1:WIDTH];
        r_lo <= w_prod[WIDTH-1:0];
      end else if (!w_div0) begin
        r_hi <= w_r;
        r_lo <= w_q;
      end
    end else if (w_accept) begin
      if (bus.op == OP_MTHI) begin
        r_hi <= bus.a;
      end
      if (bus.op == OP_MTLO) begin
        r_lo <= bus.a;
      end
    end
  end

  // Read-out select for the result path.
  always_comb begin
    bus.md_out = '0;
    unique case (bus.rd_sel)
      2'b01:   bus.md_out = r_hi;
      2'b10:   bus.md_out = r_lo;
      default: bus.md_out = '0;
    endcase
  end

  assign bus.busy = (r_state == S_BUSY);
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Randomised self-checking bench for md_unit
// against an arithmetic HI/LO model.
module tb_md_unit;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  md_unit_if #(.WIDTH(32)) bus ();

  md_unit #(
    .WIDTH(32),
    .MULT_CYCLES(5),
    .DIV_CYCLES(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain 64-bit arithmetic.
  task automatic model(
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    longint          sa, sb, q, r;
    longint unsigned ua, ub, p;
    case (op)
      3'd0: begin
        sa = $signed(a);
        sb = $signed(b);
        p = sa * sb;
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      3'd1: begin
        ua = a;
        ub = b;
        p = ua * ub;
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      3'd2: begin
        if (b != 0) begin
          sa = $signed(a);
          sb = $signed(b);
          q = sa / sb;
          r = sa % sb;
          m_lo = q[31:0];
          m_hi = r[31:0];
        end
      end
      3'd3: begin
        if (b != 0) begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endtask

  function automatic int lat(input logic [2:0] op);
    if (op <= 3'd1) return 5;
    if (op <= 3'd3) return 10;
    return 0;
  endfunction

  // Issue one op for one cycle, then count
  // cycles with busy high (bounded).
  task automatic run_op(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output int          n
  );
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    tick();
    bus.start = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy got=%b exp=0",
               bus.busy);
    end
    total++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      bad++;
      $display("FAIL reset_hilo got=%h/%h exp=0/0",
               bus.hi, bus.lo);
    end
    for (int s = 1; s <= 3; s++) begin
      bus.rd_sel = 2'(s);
      #1;
      total++;
      if (bus.md_out !== 32'h0) begin
        bad++;
        $display("FAIL reset_mdout sel=%0d got=%h exp=0",
                 s, bus.md_out);
      end
    end
  endtask

  task automatic test_mult();
    int n;
    logic [2:0] op;
    for (int k = 0; k < 2; k++) begin
      op = 3'(k);
      model(op, 32'hFFFFFFFE, 32'd3);
      run_op(op, 32'hFFFFFFFE, 32'd3, n);
      total++;
      if (n !== 5) begin
        bad++;
        $display("FAIL mult_lat op=%0d got=%0d exp=5",
                 op, n);
      end
      total++;
      if (bus.hi !== m_hi || bus.lo !== m_lo) begin
        bad++;
        $display("FAIL mult_res op=%0d got=%h/%h exp=%h/%h",
                 op, bus.hi, bus.lo, m_hi, m_lo);
      end
      bus.rd_sel = 2'b10;
      #1;
      total++;
      if (bus.md_out !== m_lo) begin
        bad++;
        $display("FAIL mult_mdout got=%h exp=%h",
                 bus.md_out, m_lo);
      end
    end
    total++;
    if (bus.hi !== 32'h2 || bus.lo !== 32'hFFFFFFFA) begin
      bad++;
      $display("FAIL multu_const got=%h/%h exp=2/fffffffa",
               bus.hi, bus.lo);
    end
  endtask

  task automatic test_div();
    int n;
    model(3'd2, 32'hFFFFFFF9, 32'd2);
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, n);
    total++;
    if (n !== 10) begin
      bad++;
      $display("FAIL div_lat got=%0d exp=10", n);
    end
    total++;
    if (bus.hi !== 32'hFFFFFFFF ||
        bus.lo !== 32'hFFFFFFFD) begin
      bad++;
      $display("FAIL div_res got=%h/%h exp=ffffffff/fffffffd",
               bus.hi, bus.lo);
    end
    model(3'd3, 32'd7, 32'd0);
    run_op(3'd3, 32'd7, 32'd0, n);
    total++;
    if (n !== 10) begin
      bad++;
      $display("FAIL div0_lat got=%0d exp=10", n);
    end
    total++;
    if (bus.hi !== m_hi || bus.lo !== m_lo) begin
      bad++;
      $display("FAIL div0_res got=%h/%h exp=%h/%h",
               bus.hi, bus.lo, m_hi, m_lo);
    end
    model(3'd2, 32'h80000000, 32'hFFFFFFFF);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, n);
    total++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h80000000) begin
      bad++;
      $display("FAIL div_ovf got=%h/%h exp=0/80000000",
               bus.hi, bus.lo);
    end
  endtask

  task automatic test_mt();
    bus.start = 1'b1;
    bus.op = 3'd4;
    bus.a = 32'h12345678;
    tick();
    m_hi = 32'h12345678;
    total++;
    if (bus.hi !== m_hi || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL mthi got=%h busy=%b exp=%h busy=0",
               bus.hi, bus.busy, m_hi);
    end
    bus.op = 3'd5;
    bus.a = 32'h9ABCDEF0;
    tick();
    bus.start = 1'b0;
    m_lo = 32'h9ABCDEF0;
    total++;
    if (bus.lo !== m_lo || bus.hi !== m_hi ||
        bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL mtlo got=%h/%h busy=%b exp=%h/%h",
               bus.hi, bus.lo, bus.busy, m_hi, m_lo);
    end
    bus.rd_sel = 2'b01;
    #1;
    total++;
    if (bus.md_out !== m_hi) begin
      bad++;
      $display("FAIL mt_mdout got=%h exp=%h",
               bus.md_out, m_hi);
    end
  endtask

  task automatic test_cancel();
    int n;
    bus.start = 1'b1;
    bus.cancel = 1'b1;
    bus.op = 3'd0;
    bus.a = 32'd9;
    bus.b = 32'd9;
    tick();
    bus.start = 1'b0;
    bus.cancel = 1'b0;
    tick();
    total++;
    if (bus.busy !== 1'b0 || bus.hi !== m_hi ||
        bus.lo !== m_lo) begin
      bad++;
      $display("FAIL cancel_start busy=%b got=%h/%h exp=%h/%h",
               bus.busy, bus.hi, bus.lo, m_hi, m_lo);
    end
    model(3'd2, 32'd100, 32'd7);
    bus.start = 1'b1;
    bus.op = 3'd2;
    bus.a = 32'd100;
    bus.b = 32'd7;
    tick();
    bus.start = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      bus.cancel = (n == 3);
      tick();
    end
    bus.cancel = 1'b0;
    total++;
    if (n !== 10 || bus.hi !== m_hi ||
        bus.lo !== m_lo) begin
      bad++;
      $display("FAIL cancel_busy n=%0d got=%h/%h exp=10 %h/%h",
               n, bus.hi, bus.lo, m_hi, m_lo);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bus.start = 1'b1;
    bus.op = 3'd0;
    bus.a = 32'd1234;
    bus.b = 32'd5678;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    total++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'h0 ||
        bus.lo !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid busy=%b got=%h/%h exp=0 0/0",
               bus.busy, bus.hi, bus.lo);
    end
    model(3'd3, 32'd1000, 32'd33);
    run_op(3'd3, 32'd1000, 32'd33, n);
    total++;
    if (n !== 10 || bus.hi !== m_hi ||
        bus.lo !== m_lo) begin
      bad++;
      $display("FAIL after_reset n=%0d got=%h/%h exp=10 %h/%h",
               n, bus.hi, bus.lo, m_hi, m_lo);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    model(3'd1, 32'hDEADBEEF, 32'h10);
    bus.start = 1'b1;
    bus.op = 3'd1;
    bus.a = 32'hDEADBEEF;
    bus.b = 32'h10;
    tick();
    bus.op = 3'd2;
    bus.a = 32'd50;
    bus.b = 32'd3;
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      bus.start = (n < 3);
      tick();
    end
    bus.start = 1'b0;
    tick();
    total++;
    if (n !== 5 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_lat n=%0d busy=%b exp=5 busy=0",
               n, bus.busy);
    end
    total++;
    if (bus.hi !== m_hi || bus.lo !== m_lo) begin
      bad++;
      $display("FAIL b2b_res got=%h/%h exp=%h/%h",
               bus.hi, bus.lo, m_hi, m_lo);
    end
  endtask

  task automatic test_random();
    int n;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [31:0] exp_md;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: begin
          a = 32'h80000000;
          b = 32'hFFFFFFFF;
        end
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      model(op, a, b);
      run_op(op, a, b, n);
      total++;
      if (n !== lat(op)) begin
        bad++;
        $display("FAIL rnd_lat i=%0d op=%0d got=%0d exp=%0d",
                 i, op, n, lat(op));
      end
      total++;
      if (bus.hi !== m_hi || bus.lo !== m_lo) begin
        bad++;
        $display("FAIL rnd_res i=%0d op=%0d a=%h b=%h got=%h/%h exp=%h/%h",
                 i, op, a, b, bus.hi, bus.lo, m_hi, m_lo);
      end
      bus.rd_sel = 2'($urandom_range(0, 3));
      #1;
      exp_md = (bus.rd_sel == 2'b01) ? m_hi :
               (bus.rd_sel == 2'b10) ? m_lo : 32'h0;
      total++;
      if (bus.md_out !== exp_md) begin
        bad++;
        $display("FAIL rnd_mdout i=%0d sel=%b got=%h exp=%h",
                 i, bus.rd_sel, bus.md_out, exp_md);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.cancel = 1'b0;
    bus.op = 3'd0;
    bus.a = '0;
    bus.b = '0;
    bus.rd_sel = 2'b00;
    test_reset();
    test_mult();
    test_div();
    test_mt();
    test_cancel();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
